// File: rtl/sphere_pair_feeder_pkg.sv
// sphere_pkg: shared constants for the sphere-pair feeder.
//   FW / PAIR_W : single-precision field width and packed pair width
//   *_LSB       : bit offsets of each field inside a packed pair, x1 in MSBs
//   FP_ZERO     : +0.0 in IEEE-754 single precision
//   field_lsb() : offset of field idx (0 = x1 ... 7 = r2) for any field width
package sphere_pkg;

    localparam int unsigned FW     = 32;
    localparam int unsigned PAIR_W = 8 * FW;

    localparam int unsigned X1_LSB = 224;
    localparam int unsigned Y1_LSB = 192;
    localparam int unsigned Z1_LSB = 160;
    localparam int unsigned R1_LSB = 128;
    localparam int unsigned X2_LSB = 96;
    localparam int unsigned Y2_LSB = 64;
    localparam int unsigned Z2_LSB = 32;
    localparam int unsigned R2_LSB = 0;

    localparam logic [FW-1:0] FP_ZERO = 32'h0000_0000;

    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned fw);
        return (7 - idx) * fw;
    endfunction

endpackage

// File: rtl/sphere_pair_feeder_pair_fifo.sv
// pair_fifo: synchronous FIFO holding packed sphere pairs.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers and level)
//   push, din   : write din at the tail; ignored when full
//   pop         : drop the head entry; ignored when empty
//   dout        : head entry, combinational read
//   full, empty : level == DEPTH / level == 0
//   level       : occupancy 0..DEPTH
module pair_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sphere_pair_feeder.sv
// sphere_pair_feeder: answers the collider's dataFetch handshake from a FIFO of
// sphere pairs written by a host.
//   clk, rst            : clock, asynchronous active-low reset
//   wr_valid/wr_ready   : host write handshake; wr_ready = !full
//   wr_data             : packed {x1,y1,z1,r1,x2,y2,z2,r2}, x1 in MSBs
//   dataFetch           : collider request level; each 0->1 edge asks for a pair
//   x1..r2              : registered pair fields presented to the collider
//   pair_valid          : outputs hold a pair popped on the latest request
//   underrun            : sticky, a request found the FIFO empty
//   clr_underrun        : synchronous clear of underrun
//   level               : FIFO occupancy 0..DEPTH
//   issued              : pairs delivered, wraps modulo 2^32
module sphere_pair_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned FW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [8*FW-1:0] wr_data,
    input  logic            dataFetch,
    output logic [FW-1:0]   x1,
    output logic [FW-1:0]   y1,
    output logic [FW-1:0]   z1,
    output logic [FW-1:0]   r1,
    output logic [FW-1:0]   x2,
    output logic [FW-1:0]   y2,
    output logic [FW-1:0]   z2,
    output logic [FW-1:0]   r2,
    output logic            pair_valid,
    output logic            underrun,
    input  logic            clr_underrun,
    output logic [AW:0]     level,
    output logic [31:0]     issued
);

    import sphere_pkg::*;

    localparam int unsigned  PW        = 8 * FW;
    localparam logic [FW-1:0] FIELD_RST = FW'(FP_ZERO);

    logic          fetch_q;
    logic          req;
    logic          push;
    logic          pop;
    logic          underrun_ev;
    logic          full;
    logic          empty;
    logic [PW-1:0] head;
    logic [FW-1:0] field_q [8];

    assign wr_ready    = ~full;
    assign push        = wr_valid & ~full;
    assign req         = dataFetch & ~fetch_q;
    // empty reflects occupancy before this edge's push, so a same-cycle write
    // is never bypassed to the outputs.
    assign pop         = req & ~empty;
    assign underrun_ev = req & empty;

    pair_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (PW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // fetch_q resets high so a dataFetch held through reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_q    <= 1'b1;
            pair_valid <= 1'b0;
            underrun   <= 1'b0;
            issued     <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                field_q[i] <= FIELD_RST;
            end
        end else begin
            fetch_q <= dataFetch;
            if (pop) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    field_q[i] <= head[field_lsb(i, FW) +: FW];
                end
                pair_valid <= 1'b1;
                issued     <= issued + 32'd1;
            end else if (underrun_ev) begin
                pair_valid <= 1'b0;
            end
            // A new underrun outranks a clear arriving on the same edge.
            if (underrun_ev) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    assign x1 = field_q[0];
    assign y1 = field_q[1];
    assign z1 = field_q[2];
    assign r1 = field_q[3];
    assign x2 = field_q[4];
    assign y2 = field_q[5];
    assign z2 = field_q[6];
    assign r2 = field_q[7];

endmodule
